// File: rtl/add8_char_pkg.sv
// rtl/add8_char_pkg.sv - shared state encoding and metric width helpers for the adder error sweep
package add8_char_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int abs_w(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int sq_w(input int w);
        return 4 * w + 2;
    endfunction

    function automatic int hd_w(input int w);
        return 2 * w + 4;
    endfunction

    // Popcount of a (w+1)-bit difference needs to hold the value w+1.
    function automatic int pc_w(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/add8_err_metric.sv
// rtl/add8_err_metric.sv - per-pair error metrics of an approximate sum against the exact sum
module add8_err_metric
    import add8_char_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]            i_a,
    input  logic [W-1:0]            i_b,
    input  logic [W:0]              i_approx,
    output logic [W:0]              o_abs,
    output logic [2*W+1:0]          o_sq,
    output logic [pc_w(W)-1:0]      o_pc,
    output logic                    o_nz
);

    localparam int PC_W = pc_w(W);

    logic [W:0]          w_exact;
    logic signed [W+1:0] w_e;
    logic [W+1:0]        w_mag;
    logic [2*W+1:0]      w_abs_x;
    logic [W:0]          w_diff;

    always_comb begin
        w_exact = {1'b0, i_a} + {1'b0, i_b};
        w_e     = $signed({1'b0, i_approx}) - $signed({1'b0, w_exact});
        // |e| never exceeds 2**(W+1)-1, so the sign bit can be dropped after negation.
        w_mag   = w_e[W+1] ? -w_e : w_e;
        o_abs   = w_mag[W:0];
        w_abs_x = {{(W+1){1'b0}}, o_abs};
        o_sq    = w_abs_x * w_abs_x;
        o_nz    = |w_e;
        w_diff  = i_approx ^ w_exact;
        o_pc    = '0;
        for (int i = 0; i <= W; i++) begin
            o_pc = o_pc + {{(PC_W-1){1'b0}}, w_diff[i]};
        end
    end

endmodule

// File: rtl/add8_err_sweep.sv
// rtl/add8_err_sweep.sv - exhaustive operand sweep and error accumulation for one approximate adder
module add8_err_sweep
    import add8_char_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                hold,
    output logic [W-1:0]        a_out,
    output logic [W-1:0]        b_out,
    input  logic [W:0]          approx_sum,
    output logic                busy,
    output logic                done,
    output logic [2*W:0]        sample_cnt,
    output logic [2*W:0]        err_cnt,
    output logic [3*W:0]        abs_err_sum,
    output logic [4*W+1:0]      sq_err_sum,
    output logic [W:0]          wce,
    output logic [2*W+3:0]      hd_sum
);

    localparam int CNT_W = cnt_w(W);
    localparam int ABS_W = abs_w(W);
    localparam int SQ_W  = sq_w(W);
    localparam int HD_W  = hd_w(W);
    localparam int PC_W  = pc_w(W);
    localparam logic [2*W-1:0] K_ONE = {{(2*W-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_next;
    logic   w_clear;
    logic   w_issue;
    logic   w_last;

    logic [2*W-1:0]   r_k;
    logic             r_v1;
    logic [W-1:0]     r_s1_a;
    logic [W-1:0]     r_s1_b;
    logic [W:0]       r_s1_approx;
    logic             r_v2;
    logic [W:0]       r_s2_abs;
    logic [2*W+1:0]   r_s2_sq;
    logic [PC_W-1:0]  r_s2_pc;
    logic             r_s2_nz;

    logic [W:0]       w_abs;
    logic [2*W+1:0]   w_sq;
    logic [PC_W-1:0]  w_pc;
    logic             w_nz;

    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [ABS_W-1:0] r_abs_sum;
    logic [SQ_W-1:0]  r_sq_sum;
    logic [W:0]       r_wce;
    logic [HD_W-1:0]  r_hd_sum;

    add8_err_metric #(.W(W)) u_metric (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_approx (r_s1_approx),
        .o_abs    (w_abs),
        .o_sq     (w_sq),
        .o_pc     (w_pc),
        .o_nz     (w_nz)
    );

    assign w_last = (r_k == {(2*W){1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // start is honoured regardless of hold; issue happens only on un-held SWEEP cycles.
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next  = SWEEP;
                    w_clear = 1'b1;
                end
            end
            SWEEP: begin
                if (!hold) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!r_v1 && !r_v2) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k          <= '0;
            r_v1         <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_approx  <= '0;
            r_v2         <= 1'b0;
            r_s2_abs     <= '0;
            r_s2_sq      <= '0;
            r_s2_pc      <= '0;
            r_s2_nz      <= 1'b0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_abs_sum    <= '0;
            r_sq_sum     <= '0;
            r_wce        <= '0;
            r_hd_sum     <= '0;
        end else if (w_clear) begin
            r_k          <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_abs_sum    <= '0;
            r_sq_sum     <= '0;
            r_wce        <= '0;
            r_hd_sum     <= '0;
        end else if (!hold) begin
            r_v1 <= w_issue;
            if (w_issue) begin
                r_s1_a      <= r_k[2*W-1:W];
                r_s1_b      <= r_k[W-1:0];
                r_s1_approx <= approx_sum;
                if (!w_last) begin
                    r_k <= r_k + K_ONE;
                end
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_abs <= w_abs;
                r_s2_sq  <= w_sq;
                r_s2_pc  <= w_pc;
                r_s2_nz  <= w_nz;
            end
            if (r_v2) begin
                r_sample_cnt <= r_sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_err_cnt    <= r_err_cnt + {{(CNT_W-1){1'b0}}, r_s2_nz};
                r_abs_sum    <= r_abs_sum + {{(ABS_W-W-1){1'b0}}, r_s2_abs};
                r_sq_sum     <= r_sq_sum + {{(SQ_W-2*W-2){1'b0}}, r_s2_sq};
                r_hd_sum     <= r_hd_sum + {{(HD_W-PC_W){1'b0}}, r_s2_pc};
                if (r_s2_abs > r_wce) begin
                    r_wce <= r_s2_abs;
                end
            end
        end
    end

    assign a_out       = r_k[2*W-1:W];
    assign b_out       = r_k[W-1:0];
    assign busy        = (r_state == SWEEP) || (r_state == DRAIN);
    assign done        = (r_state == DONE);
    assign sample_cnt  = r_sample_cnt;
    assign err_cnt     = r_err_cnt;
    assign abs_err_sum = r_abs_sum;
    assign sq_err_sum  = r_sq_sum;
    assign wce         = r_wce;
    assign hd_sum      = r_hd_sum;

endmodule
